// File: rtl/onehot_drain_encoder_if.sv
// Request/beat bus between collection logic, the onehot_drain_encoder and dispatch.
// The encoder attaches through the slave modport; the driving side uses master.
interface onehot_drain_encoder_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic             enable;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_err;
    logic [IDX_W:0]   out_count;

    modport master (
        output enable, mode, in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_err, out_count
    );

    modport slave (
        input  enable, mode, in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_err, out_count
    );
endinterface

// File: rtl/onehot_drain_encoder.sv
// Registered one-hot encoder / set-bit drainer: ONEHOT returns one index with an error flag,
// DRAIN emits every set bit lowest-first, one beat per output transfer.
module onehot_drain_encoder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    onehot_drain_encoder_if.slave bus
);
    localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    state_t           state,     state_nxt;
    logic [WIDTH-1:0] pending,   pending_nxt;
    logic             mode_q,    mode_nxt;
    logic             out_valid, out_valid_nxt;
    logic [IDX_W-1:0] out_idx,   out_idx_nxt;
    logic             out_last,  out_last_nxt;
    logic             out_err,   out_err_nxt;
    logic [CNT_W-1:0] out_count, out_count_nxt;

    logic             ready_c;
    logic             accept_c;
    logic             xfer_c;
    logic [IDX_W-1:0] in_low_c;
    logic [CNT_W-1:0] in_pop_c;
    logic [WIDTH-1:0] in_rest_c;
    logic [WIDTH-1:0] pend_rest_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            out_count <= '0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            mode_q    <= mode_nxt;
            out_valid <= out_valid_nxt;
            out_idx   <= out_idx_nxt;
            out_last  <= out_last_nxt;
            out_err   <= out_err_nxt;
            out_count <= out_count_nxt;
        end
    end

    // Clearing the lowest set bit via v & (v-1) yields the remaining work vector.
    always_comb begin
        ready_c     = rst_n & bus.enable & (state == IDLE) & (~out_valid | bus.out_ready);
        accept_c    = bus.in_valid & ready_c;
        xfer_c      = out_valid & bus.out_ready;
        in_low_c    = lowest_set(bus.in_vec);
        in_pop_c    = popcount(bus.in_vec);
        in_rest_c   = bus.in_vec & (bus.in_vec - WIDTH'(1));
        pend_rest_c = pending & (pending - WIDTH'(1));

        state_nxt     = state;
        pending_nxt   = pending;
        mode_nxt      = mode_q;
        out_valid_nxt = out_valid & ~bus.out_ready;
        out_idx_nxt   = out_idx;
        out_last_nxt  = out_last;
        out_err_nxt   = out_err;
        out_count_nxt = out_count;

        case (state)
            IDLE: begin
                if (accept_c) begin
                    out_valid_nxt = 1'b1;
                    out_count_nxt = in_pop_c;
                    mode_nxt      = bus.mode;
                    if (!bus.mode) begin
                        out_last_nxt = 1'b1;
                        out_err_nxt  = (in_pop_c != CNT_W'(1));
                        out_idx_nxt  = (in_pop_c == CNT_W'(1)) ? in_low_c : '0;
                    end else if (in_pop_c == '0) begin
                        out_idx_nxt  = '0;
                        out_err_nxt  = 1'b1;
                        out_last_nxt = 1'b1;
                    end else begin
                        out_idx_nxt  = in_low_c;
                        out_err_nxt  = 1'b0;
                        pending_nxt  = in_rest_c;
                        out_last_nxt = (in_rest_c == '0);
                        if (in_rest_c != '0) state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Only the mode latched at accept governs; live mode/enable are ignored here.
                if (xfer_c && mode_q) begin
                    out_valid_nxt = 1'b1;
                    out_idx_nxt   = lowest_set(pending);
                    out_err_nxt   = 1'b0;
                    pending_nxt   = pend_rest_c;
                    out_last_nxt  = (pend_rest_c == '0);
                    if (pend_rest_c == '0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = out_valid;
    assign bus.out_idx   = out_idx;
    assign bus.out_last  = out_last;
    assign bus.out_err   = out_err;
    assign bus.out_count = out_count;

endmodule

// File: tb/tb_onehot_drain_encoder.sv
// Randomised and directed checks of onehot_drain_encoder against a beat-list reference model.
module tb_onehot_drain_encoder;
    localparam int unsigned WIDTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    onehot_drain_encoder_if #(.WIDTH(WIDTH)) bus();

    onehot_drain_encoder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit last;
        bit err;
        int count;
    } beat_t;

    beat_t exp_q[$];
    int    checks     = 0;
    int    failures   = 0;
    bit    started    = 0;
    bit    post_reset = 0;
    bit    rnd_ready  = 0;
    bit    ready_val  = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Position of the k-th (0-based) set bit, -1 if absent.
    function automatic int kth_set(input logic [WIDTH-1:0] v, input int k);
        int n = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (v[i]) begin
                if (n == k) return i;
                n++;
            end
        end
        return -1;
    endfunction

    function automatic beat_t onehot_beat(input logic [WIDTH-1:0] v);
        beat_t b;
        int p = $countones(v);
        b.idx   = (p == 1) ? kth_set(v, 0) : 0;
        b.last  = 1'b1;
        b.err   = (p != 1);
        b.count = p;
        return b;
    endfunction

    task automatic model_accept(input logic [WIDTH-1:0] v, input logic m);
        int p = $countones(v);
        beat_t b;
        if (!m) begin
            exp_q.push_back(onehot_beat(v));
        end else if (p == 0) begin
            b.idx = 0; b.last = 1; b.err = 1; b.count = 0;
            exp_q.push_back(b);
        end else begin
            for (int k = 0; k < p; k++) begin
                b.idx = kth_set(v, k); b.last = (k == p - 1); b.err = 0; b.count = p;
                exp_q.push_back(b);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_val;
    end

    // Compare process: checks outputs each cycle, then advances the model to the next edge.
    always @(negedge clk) begin
        bit    exp_ready;
        beat_t h;
        exp_ready = rst_n && bus.enable &&
                    (exp_q.size() == 0 || (exp_q.size() == 1 && bus.out_ready));
        if (started) begin
            chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0 && bus.out_valid) begin
                h = exp_q[0];
                chk("out_idx", 32'(bus.out_idx), 32'(h.idx));
                chk("out_last", 32'(bus.out_last), 32'(h.last));
                chk("out_err", 32'(bus.out_err), 32'(h.err));
                chk("out_count", 32'(bus.out_count), 32'(h.count));
            end
            if (post_reset) begin
                chk("rst_valid", 32'(bus.out_valid), 32'd0);
                chk("rst_idx", 32'(bus.out_idx), 32'd0);
                chk("rst_last", 32'(bus.out_last), 32'd0);
                chk("rst_err", 32'(bus.out_err), 32'd0);
                chk("rst_count", 32'(bus.out_count), 32'd0);
            end
        end
        if (!rst_n) begin
            exp_q.delete();
            started    = 1;
            post_reset = 1;
        end else begin
            post_reset = 0;
            if (started) begin
                if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
                if (bus.in_valid && exp_ready) model_accept(bus.in_vec, bus.mode);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] v, input logic m);
        int n = 0;
        bus.in_vec   = v;
        bus.mode     = m;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: vector %h never accepted", v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drained();
        for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d beats outstanding", exp_q.size());
        end
    endtask

    initial begin
        beat_t b;
        bus.enable   = 1'b1;
        bus.mode     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_vec   = '0;
        bus.out_ready = 1'b1;

        // Pin the reference model against hand-computed values.
        chk("model_k0", 32'(kth_set(16'h8421, 0)), 32'd0);
        chk("model_k1", 32'(kth_set(16'h8421, 1)), 32'd5);
        chk("model_k2", 32'(kth_set(16'h8421, 2)), 32'd10);
        chk("model_k3", 32'(kth_set(16'h8421, 3)), 32'd15);
        b = onehot_beat(16'h0400);
        chk("model_oh_idx", 32'(b.idx), 32'd10);
        chk("model_oh_err", 32'(b.err), 32'd0);
        b = onehot_beat(16'h0003);
        chk("model_mh_err", 32'(b.err), 32'd1);
        chk("model_mh_cnt", 32'(b.count), 32'd2);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ONEHOT basics, back-to-back
        send(16'h0400, 0);
        send(16'h0001, 0);
        send(16'h0000, 0);
        send(16'h0003, 0);
        idle();
        wait_drained();

        // DRAIN with full throughput
        send(16'h8421, 1);
        idle();
        wait_drained();

        // DRAIN under backpressure; next vector accepted as the last beat transfers
        ready_val = 0;
        send(16'h0006, 1);
        idle();
        repeat (3) @(posedge clk);
        ready_val = 1;
        send(16'h0001, 0);
        idle();
        wait_drained();

        // Reset in the middle of a drain
        send(16'hFFFF, 1);
        idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(16'h0010, 0);
        idle();
        wait_drained();

        // enable low blocks acceptance
        bus.enable   = 1'b0;
        bus.in_vec   = 16'h0020;
        bus.mode     = 1'b0;
        bus.in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1 idle();
        bus.enable = 1'b1;

        // Mode change and enable drop during a drain are ignored
        send(16'h0A00, 1);
        idle();
        bus.mode   = 1'b0;
        bus.enable = 1'b0;
        wait_drained();
        bus.enable = 1'b1;

        // Randomised traffic with random backpressure
        rnd_ready = 1;
        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] v;
            case ($urandom_range(0, 3))
                0:       v = '0;
                1:       v = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
                2:       v = WIDTH'($urandom & $urandom & $urandom);
                default: v = WIDTH'($urandom);
            endcase
            send(v, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) begin
                idle();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        idle();
        wait_drained();
        rnd_ready = 0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
